// File: rtl/sa_ram_ctrl_pkg.sv
// Shared defaults for the SA RAM-backed FIFO controllers (4 x 128 registered-read RAM).
package sa_ram_ctrl_pkg;

  localparam int SA_RAM_DEPTH = 4;
  localparam int SA_RAM_AW    = 2;
  localparam int SA_RAM_DW    = 128;
  localparam int SA_RAM_OCCW  = SA_RAM_AW + 1;

endpackage

// File: rtl/sa_ram_rd_pipe.sv
// Two-stage read tracker for a registered-read RAM: stage 1 = read address latched,
// stage 2 = output register holds data not yet popped.
module sa_ram_rd_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic avail,
  input  logic rd_prdy,
  output logic ram_re,
  output logic ram_ore,
  output logic vld_p2
);

  logic vld_p1;

  // Output register may load when empty or being drained this cycle.
  always_comb begin
    ram_ore = vld_p1 & (~vld_p2 | rd_prdy);
    ram_re  = avail & (~vld_p1 | ram_ore);
  end

  // p1: address latched in RAM -> p2: data in RAM output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= ram_re | (vld_p1 & ~ram_ore);
      vld_p2 <= ram_ore | (vld_p2 & ~rd_prdy);
    end
  end

endmodule

// File: rtl/sa_ram_rwsp_fifo_rdctl.sv
// Valid/ready FIFO controller driving an external 1R1W registered-read RAM.
// Optional SA_FIFO_CUT_THROUGH_EN: a push into an empty read queue issues re in the same cycle.
module sa_ram_rwsp_fifo_rdctl
  import sa_ram_ctrl_pkg::*;
#(
  parameter int DEPTH = SA_RAM_DEPTH,
  parameter int AW    = SA_RAM_AW,
  parameter int DW    = SA_RAM_DW
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_pd
);

  localparam int OCCW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OCCW-1:0] occ;
  logic [OCCW-1:0] unrd;
  logic            push;
  logic            avail;
  logic            full;
  logic            vld_p2;

  // An entry is released once the RAM output register has captured it, so
  // occ counts entries still needed in the array, not items in the output reg.
  assign full    = (occ == OCCW'(DEPTH));
  assign wr_prdy = ~full;
  assign push    = wr_pvld & wr_prdy;

`ifdef SA_FIFO_CUT_THROUGH_EN
  assign avail = (unrd != '0) | push;
`else
  assign avail = (unrd != '0);
`endif

  sa_ram_rd_pipe u_rd_pipe (
    .clk     (nvdla_core_clk),
    .rst_n   (nvdla_core_rstn),
    .avail   (avail),
    .rd_prdy (rd_prdy),
    .ram_re  (ram_re),
    .ram_ore (ram_ore),
    .vld_p2  (vld_p2)
  );

  assign rd_pvld       = vld_p2;
  assign rd_pd         = ram_dout;
  assign ram_wa        = wr_ptr;
  assign ram_we        = push;
  assign ram_di        = wr_pd;
  assign ram_ra        = rd_ptr;
  assign ram_pwrbus_pd = pwrbus_ram_pd;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      unrd   <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (ram_re) rd_ptr <= rd_ptr + AW'(1);
      case ({push, ram_ore})
        2'b10:   occ <= occ + OCCW'(1);
        2'b01:   occ <= occ - OCCW'(1);
        default: occ <= occ;
      endcase
      case ({push, ram_re})
        2'b10:   unrd <= unrd + OCCW'(1);
        2'b01:   unrd <= unrd - OCCW'(1);
        default: unrd <= unrd;
      endcase
    end
  end

endmodule
